// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receiver FSM encoding, parity modes and baud increment math.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // round(baud * ovs * 2^acc_w / clk_hz)
  function automatic longint unsigned baud_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs,
    input longint unsigned acc_w
  );
    longint unsigned num;
    num = baud * ovs * (64'd1 << acc_w);
    return (num + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received words.
// Ports: clk, reset, push/din, pop, dout (head word), empty, full.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised RS-232 receiver: oversampled majority vote, parity/stop
// checks, break/overrun/idle detection and a valid/ready output buffer.
// Ports: clk, reset (sync, high), rxd, cfg_parity, cfg_two_stop,
//   rx_data/rx_err_frame/rx_err_par/rx_valid/rx_ready handshake,
//   rx_overrun, rx_break, rx_idle, rx_eop.
// UART_RX_FIFO_EN selects a FIFO_DEPTH FIFO instead of one holding reg.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVS        = 16,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IDLE_BITS  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err_frame,
  output logic              rx_err_par,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              rx_break,
  output logic              rx_idle,
  output logic              rx_eop
);

  localparam int unsigned PH_W  = $clog2(OVS);
  localparam int unsigned IDL_W = $clog2(IDLE_BITS + 1);
  localparam int unsigned BUF_W = DATA_W + 2;

  localparam logic [ACC_W:0] INC =
    (ACC_W+1)'(baud_inc(CLK_HZ, BAUD, OVS, ACC_W));

  localparam logic [PH_W-1:0] PH_LO   = PH_W'(OVS/2 - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS/2);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(OVS/2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [IDL_W-1:0] SAT    = IDL_W'(IDLE_BITS);
  localparam logic [3:0] LAST_BIT     = 4'(DATA_W - 1);

  logic [ACC_W:0]      acc_q, acc_d;
  logic [1:0]          sync_q, sync_d;
  rx_state_t           state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                s0_q, s0_d;
  logic                s1_q, s1_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          par_cfg_q, par_cfg_d;
  logic                two_stop_q, two_stop_d;
  logic                par_bit_q, par_bit_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic [IDL_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                eop_q, eop_d;
  logic                brk_q, brk_d;
  logic                ovr_q, ovr_d;

  logic                tick, rxd_s, maj, mid, bit_end;
  logic                frm_fin, brk_cond, dx, commit;
  logic [BUF_W-1:0]    commit_word;
  logic                pop, push, full, buf_vld;
  logic [BUF_W-1:0]    buf_word;

  assign tick    = acc_q[ACC_W];
  assign rxd_s   = sync_q[1];
  assign maj     = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
  assign mid     = (ph_q == PH_HI);
  assign bit_end = (ph_q == PH_LAST);
  assign dx      = (^data_q) ^ maj;

  // Frame error including the stop sample being voted right now
  assign frm_fin  = frm_err_q | ~maj;
  assign brk_cond = frm_fin && (data_q == '0) &&
                    !((par_cfg_q != PAR_NONE) && par_bit_q);
  assign commit_word = {frm_fin, par_err_q, data_q};

  always_comb begin
    acc_d      = {1'b0, acc_q[ACC_W-1:0]} + INC;
    sync_d     = {sync_q[0], rxd};
    state_d    = state_q;
    ph_d       = ph_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_cfg_d  = par_cfg_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    idle_cnt_d = idle_cnt_q;
    commit     = 1'b0;
    brk_d      = 1'b0;
    if (tick) begin
      ph_d = ph_q + PH_W'(1);
      if (ph_q == PH_LO)  s0_d = rxd_s;
      if (ph_q == PH_MID) s1_d = rxd_s;
      unique case (state_q)
        RX_IDLE: begin
          if (!rxd_s) begin
            state_d = RX_START;
            ph_d    = '0;
          end else if (bit_end && idle_cnt_q != SAT) begin
            idle_cnt_d = idle_cnt_q + IDL_W'(1);
          end
        end
        RX_START: begin
          if (mid && maj) begin
            state_d = RX_IDLE;
            ph_d    = '0;
          end else if (bit_end) begin
            state_d    = RX_DATA;
            bit_cnt_d  = '0;
            par_cfg_d  = cfg_parity;
            two_stop_d = cfg_two_stop;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
          end
        end
        RX_DATA: begin
          if (mid) data_d = {maj, data_q[DATA_W-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_d = (par_cfg_q != PAR_NONE) ? RX_PARITY
                                                : RX_STOP1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (mid) begin
            par_bit_d = maj;
            unique case (par_cfg_q)
              PAR_ODD:  par_err_d = ~dx;
              PAR_EVEN: par_err_d = dx;
              PAR_MARK: par_err_d = ~maj;
              default:  par_err_d = 1'b0;
            endcase
          end
          if (bit_end) state_d = RX_STOP1;
        end
        RX_STOP1, RX_STOP2: begin
          if (mid) begin
            frm_err_d = frm_fin;
            if (!(state_q == RX_STOP1 && two_stop_q)) begin
              // Leave at mid-stop so the next start edge resyncs
              ph_d = '0;
              if (brk_cond) begin
                brk_d   = 1'b1;
                state_d = RX_BRK_WAIT;
              end else begin
                commit  = 1'b1;
                state_d = RX_IDLE;
              end
            end
          end else if (bit_end && state_q == RX_STOP1) begin
            state_d = RX_STOP2;
          end
        end
        RX_BRK_WAIT: begin
          if (rxd_s) begin
            state_d = RX_IDLE;
            ph_d    = '0;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
    if (state_q != RX_IDLE) idle_cnt_d = '0;
    eop_d = (idle_cnt_d == SAT) && (idle_cnt_q != SAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      ph_q       <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_cfg_q  <= PAR_NONE;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      idle_cnt_q <= '0;
      eop_q      <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      ph_q       <= ph_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_cfg_q  <= par_cfg_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      idle_cnt_q <= idle_cnt_d;
      eop_q      <= eop_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign pop   = buf_vld & rx_ready;
  assign push  = commit & ~full;
  assign ovr_d = commit & full;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty, fifo_full;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUF_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (commit_word),
    .pop   (pop),
    .dout  (buf_word),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign buf_vld = ~fifo_empty;
  // A pop in the same cycle frees a slot for the commit
  assign full    = fifo_full & ~pop;
`else
  logic [BUF_W-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             unused_depth;

  assign unused_depth = ^32'(FIFO_DEPTH);

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q & ~pop;
    if (push) begin
      hold_d     = commit_word;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign buf_word = hold_q;
  assign buf_vld  = hold_vld_q;
  assign full     = hold_vld_q & ~pop;
`endif

  assign rx_valid     = buf_vld;
  assign rx_data      = buf_vld ? buf_word[DATA_W-1:0] : '0;
  assign rx_err_par   = buf_vld & buf_word[DATA_W];
  assign rx_err_frame = buf_vld & buf_word[DATA_W+1];
  assign rx_overrun   = ovr_q;
  assign rx_break     = brk_q;
  assign rx_idle      = (idle_cnt_q == SAT);
  assign rx_eop       = eop_q;

endmodule
